// File: rtl/shift_add_mult_ctrl.sv
// shift_add_mult_ctrl
// Sequential radix-2 shift-and-add multiplier with valid/ready handshakes on
// both sides. One 2*WIDTH-bit adder is reused once per cycle, so a product
// takes WIDTH iterations instead of needing an array of adders.
//
// Optional build macro SHIFT_ADD_MULT_EARLY_TERM_EN: when defined, RUN ends as
// soon as the remaining multiplier bits are all zero. The product value does
// not change, only the number of RUN cycles. When the macro is undefined, RUN
// always lasts exactly WIDTH cycles and no zero-detect logic is built.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one shift/add iteration per cycle
// DONE  | product presented with out_valid, held until out_ready

module shift_add_mult_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [PW-1:0]     acc_q;
    logic [PW-1:0]     mcand_q;
    logic [WIDTH-1:0]  mplier_q;
    logic [CW-1:0]     cnt_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;

    logic [PW-1:0]     acc_d;
    logic [PW-1:0]     mcand_d;
    logic [WIDTH-1:0]  mplier_d;
    logic [CW-1:0]     cnt_d;
    logic              last_iter;

    // Datapath for one iteration: conditional add, then shift both operands.
    always_comb begin
        acc_d    = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
    end

    // Decide whether the current RUN cycle is the final iteration.
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
    always_comb begin
        last_iter = (cnt_q == LAST_CNT) || (mplier_d == '0);
    end
`else
    always_comb begin
        last_iter = (cnt_q == LAST_CNT);
    end
`endif

    // Control FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        mcand_q    <= {{WIDTH{1'b0}}, a};
                        mplier_q   <= b;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_d;
                    mplier_q <= mplier_d;
                    cnt_q    <= cnt_d;
                    if (last_iter) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    // No operand accept here; in_ready only rises once back in IDLE.
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // acc is left untouched after handoff, so product keeps the last result.
    assign product   = acc_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed testbench for shift_add_mult_ctrl at WIDTH=8.
// Run lengths follow SHIFT_ADD_MULT_EARLY_TERM_EN when it is defined.

module tb_shift_add_mult_ctrl;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [2*W-1:0] product;
    logic           busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    shift_add_mult_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("%s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected number of RUN cycles for multiplier value m.
    function automatic int run_len(input logic [W-1:0] m);
        int k;
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
        k = 1;
        for (int i = 0; i < W; i++) begin
            if (m[i]) k = i + 1;
        end
`else
        k = W;
`endif
        return k;
    endfunction

    // One complete transaction with out_ready held high, checking latency.
    task automatic mult(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input int exp_p);
        int k;
        k = run_len(tb_v);
        in_valid = 1'b1;
        a = ta;
        b = tb_v;
        check("accept_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        a = ~ta;
        b = ~tb_v;
        check("run_busy", {31'd0, busy}, 32'd1);
        check("run_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 1; i <= k; i++) begin
            check("no_early_valid", {31'd0, out_valid}, 32'd0);
            step();
        end
        check("out_valid_at_latency", {31'd0, out_valid}, 32'd1);
        check("product", {16'd0, product}, exp_p);
        check("done_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        check("idle_out_valid", {31'd0, out_valid}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_product_kept", {16'd0, product}, exp_p);
    endtask

    logic [W-1:0] pa [3];
    logic [W-1:0] pb [3];
    int           pe [3];

    initial begin
        int n_in;
        int n_out;
        int last_acc;
        logic accept;

        // Reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_product", {16'd0, product}, 32'd0);

        // Basic products and operand corners
        mult(8'd13, 8'd11, 143);
        mult(8'd255, 8'd255, 65025);
        mult(8'd0, 8'd200, 0);
        mult(8'd200, 8'd0, 0);
        mult(8'd50, 8'd1, 50);
        mult(8'd77, 8'd0, 0);
        mult(8'd7, 8'd128, 896);
        mult(8'd3, 8'd5, 15);

        // Back-pressure: out_ready low for 5 cycles of out_valid
        out_ready = 1'b0;
        in_valid = 1'b1;
        a = 8'd100;
        b = 8'd7;
        step();
        in_valid = 1'b0;
        for (int i = 1; i <= run_len(8'd7); i++) step();
        for (int i = 0; i < 5; i++) begin
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
            check("stall_product", {16'd0, product}, 32'd700);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            in_valid = 1'b1;
            a = 8'd17;
            b = 8'd3;
            step();
        end
        check("stall6_out_valid", {31'd0, out_valid}, 32'd1);
        check("stall6_product", {16'd0, product}, 32'd700);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("post_stall_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_stall_out_valid", {31'd0, out_valid}, 32'd0);
        check("post_stall_product", {16'd0, product}, 32'd700);

        // Reset during the 4th RUN cycle aborts the operation
        in_valid = 1'b1;
        a = 8'd9;
        b = 8'd9;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        check("pre_abort_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_product", {16'd0, product}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            check("abort_no_valid", {31'd0, out_valid}, 32'd0);
            step();
        end

        // Back-to-back with in_valid held high
        pa[0] = 8'd17;  pb[0] = 8'd23;  pe[0] = 391;
        pa[1] = 8'd255; pb[1] = 8'd254; pe[1] = 64770;
        pa[2] = 8'd6;   pb[2] = 8'd129; pe[2] = 774;
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = pa[0];
        b = pb[0];
        n_in = 0;
        n_out = 0;
        last_acc = 0;
        for (int c = 0; c < 80 && n_out < 3; c++) begin
            if (out_valid) begin
                check("b2b_product", {16'd0, product}, pe[n_out]);
                n_out++;
            end
            accept = in_valid && in_ready;
            if (accept) begin
                if (n_in > 0) check("b2b_gap", cyc - last_acc, run_len(pb[n_in-1]) + 2);
                last_acc = cyc;
                n_in++;
            end
            step();
            if (accept) begin
                if (n_in < 3) begin
                    a = pa[n_in];
                    b = pb[n_in];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("b2b_accepts", n_in, 3);
        check("b2b_results", n_out, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shift_add_mult_ctrl.md
Name: shift_add_mult_ctrl

Overview:
- Sequential radix-2 shift-and-add multiplier.
- One shared WIDTH*2-bit adder is reused over successive cycles instead of an array of half/full adders.
- Sequences operand load, iteration and result handoff, with valid/ready handshakes on both sides.
- Sits beside the combinational array multipliers as the low-area option for non-throughput-critical paths.

Parameters:
- WIDTH, 8, operand width in bits (>= 2); product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operands a/b valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  multiplicand, unsigned
- b  input  WIDTH  multiplier, unsigned
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- product  output  2*WIDTH  unsigned a*b
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst=1 at a rising edge):
  - state <= IDLE.
  - Accumulator, shifted multiplicand, multiplier shift register and iteration counter <= 0.
  - Outputs after reset: in_ready=1, out_valid=0, busy=0, product=0.
- Reset has priority over everything, including mid-RUN and DONE. An in-flight operation is discarded with no output.
- State IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: mcand <= zero-extended a (2*WIDTH), mplier <= b, acc <= 0, cnt <= 0, state <= RUN.
  - Otherwise hold.
- State RUN (one iteration per cycle):
  - in_ready=0.
  - If mplier[0]: acc <= acc + mcand, mod 2^(2*WIDTH). No overflow is possible for unsigned operands.
  - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt + 1.
  - When cnt == WIDTH-1 in this cycle, state <= DONE.
- State DONE:
  - out_valid=1; product = acc, held stable while out_valid && !out_ready.
  - On out_valid&&out_ready: state <= IDLE.
  - in_ready stays 0 until IDLE; no operand accept in the same cycle as result handoff.
- Latency:
  - Input handshake at edge of cycle t; RUN occupies cycles t+1..t+WIDTH; out_valid first high in cycle t+WIDTH+1.
  - Minimum issue interval is WIDTH+2 cycles with out_ready held high.
- Inputs are ignored outside IDLE. a/b changing during RUN has no effect.
- product outside DONE:
  - Equals the last delivered product (acc is not cleared until the next accept).
  - After reset it is 0.
  - Verification checks product only when out_valid=1.
- cnt width: $clog2(WIDTH+1) bits.
- busy = (state != IDLE).

Optional Feature:
- Macro: SHIFT_ADD_MULT_EARLY_TERM_EN.
- Defined:
  - RUN exits to DONE at the end of the first cycle in which the post-shift mplier is zero, or when cnt == WIDTH-1, whichever comes first.
  - RUN length k = (index of MSB set in b) + 1; b=0 gives k=1.
  - out_valid first high in cycle t+k+1.
  - Product value is identical to the non-early-termination result.
- Undefined: RUN is always exactly WIDTH cycles. No zero-detect logic is present.

Test Plan (WIDTH=8):
- Reset, then a=13, b=11 accepted at cycle t, out_ready=1 -> out_valid high only in cycle t+9, product=143; in_ready returns to 1 at t+10.
- a=255, b=255 -> product=65025 at t+9. Then a=0, b=200 -> product=0. Then a=200, b=0 -> product=0.
- a=100, b=7, out_ready held 0 for 5 cycles after out_valid -> product=700 stable and out_valid high throughout; in_ready=0; a new in_valid is ignored; handshake on the 6th cycle -> IDLE next cycle.
- Accept a=9, b=9; assert rst during the 4th RUN cycle -> next cycle in_ready=1, out_valid=0, product=0, busy=0; no out_valid pulse for the aborted operation.
- Back-to-back: 3 operand pairs with in_valid held high and out_ready=1 -> accepts spaced exactly 10 cycles apart; products match a*b in order.
- SHIFT_ADD_MULT_EARLY_TERM_EN defined:
  - a=50, b=1 -> out_valid at t+2, product=50.
  - b=0 -> out_valid at t+2, product=0.
  - b=128 -> out_valid at t+9.
  - a=3, b=5 -> out_valid at t+4, product=15.
